// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared constants for the bit-serial adder.
//   - Encoding of the three controller states (IDLE / RUN / DONE).
//   - Helper that derives the bit-counter width from the operand width.
// No ports (package).
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // The counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/fulladder.sv
// -----------------------------------------------------------------------------
// fulladder
//   One-bit combinational full adder, used as the bit slice of serial_adder.
// Ports:
//   i_a, i_b  in   addend bits
//   i_cin     in   carry in
//   o_sum     out  i_a ^ i_b ^ i_cin
//   o_cout    out  majority(i_a, i_b, i_cin)
// -----------------------------------------------------------------------------
module fulladder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder. Operands are captured on an in_valid/in_ready
//   handshake, added LSB first through a single fulladder over WIDTH cycles,
//   and the result is held on out_sum/out_cout until out_valid & out_ready.
//
// Optional feature macro: SERIAL_ADDER_OVF_EN
//   When defined, adds port out_ovf (signed overflow = carry into MSB XOR
//   carry out of MSB), registered in the last RUN cycle and held with out_sum.
//
// Ports:
//   clk        in   clock, all state on posedge
//   rst        in   synchronous active-high reset
//   in_valid   in   operands present
//   in_ready   out  high in IDLE only
//   in_a/in_b  in   WIDTH-bit operands
//   in_cin     in   carry in
//   out_valid  out  high in DONE only
//   out_ready  in   sink accepts result
//   out_sum    out  (A+B+cin) mod 2^WIDTH
//   out_cout   out  carry out of MSB
//   out_ovf    out  signed overflow (SERIAL_ADDER_OVF_EN only)
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int CNT_W = cnt_w(WIDTH);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic             r_carry;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;
  logic             w_sum_bit;
  logic             w_fa_cout;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  fulladder u_fa (
    .i_a    (r_a_sr[0]),
    .i_b    (r_b_sr[0]),
    .i_cin  (r_carry),
    .o_sum  (w_sum_bit),
    .o_cout (w_fa_cout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs decode the registered state only
  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_DONE);
  end

  // Datapath: operand load in IDLE, one bit per cycle in RUN, hold in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a_sr  <= in_a;
            r_b_sr  <= in_b;
            r_carry <= in_cin;
            r_cnt   <= '0;
          end
        end
        ST_RUN: begin
          // LSB-first: each new sum bit enters at the top, so after WIDTH
          // shifts bit 0 of the result has reached bit 0 of r_sum_sr.
          r_sum_sr <= {w_sum_bit, r_sum_sr[WIDTH-1:1]};
          r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_carry  <= w_fa_cout;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) r_cout <= w_fa_cout;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;

  // In the MSB slice r_carry is the carry into the MSB
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == ST_RUN && w_last) begin
      r_ovf <= r_carry ^ w_fa_cout;
    end
  end

  assign out_ovf = r_ovf;
`endif

  assign out_sum  = r_sum_sr;
  assign out_cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Self-checking bench for serial_adder (WIDTH=8). Directed corner cases plus
//   random operands, checked against an arithmetic reference model.
//   Optional out_ovf checks follow SERIAL_ADDER_OVF_EN.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_cin = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_ready;
  logic         out_valid;
  logic         out_cout;
  logic [W-1:0] out_sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic         out_ovf;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic
  function automatic logic [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
    return {1'b0, a} + {1'b0, b} + (W+1)'(c);
  endfunction

  function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic c);
    int s;
    s = int'($signed(a)) + int'($signed(b)) + int'(c);
    return (s > (2**(W-1)) - 1) || (s < -(2**(W-1)));
  endfunction

  task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic c);
    logic [W:0] e;
    e = model_sum(a, b, c);
    chk({tag, ".sum"},  32'(out_sum),  32'(e[W-1:0]));
    chk({tag, ".cout"}, 32'(out_cout), 32'(e[W]));
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, ".ovf"},  32'(out_ovf),  32'(model_ovf(a, b, c)));
`endif
  endtask

  // One operation from IDLE; result held 'hold' extra cycles under backpressure.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input string tag, input int hold);
    int k;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    // Scramble the bus: operands must only be sampled on acceptance
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, ".latency"}, 32'(k), 32'd8);
    check_result(tag, a, b, c);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
      check_result({tag, ".hold"}, a, b, c);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".back_idle"}, 32'(in_ready), 32'd1);
    chk({tag, ".valid_low"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int acc_t[$];
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic qc[$];
    int cyc;
    int nres;
    logic acc;

    // Reset state
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.sum",       32'(out_sum),   32'd0);
    chk("rst.cout",      32'(out_cout),  32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst.ovf",       32'(out_ovf),   32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed corners
    run_op(8'h5A, 8'h3C, 1'b0, "t1", 0);
    chk("t1.sum_const", 32'(out_sum), 32'h96);
    run_op(8'hFF, 8'h01, 1'b0, "t2a", 0);
    run_op(8'hFF, 8'h00, 1'b1, "t2b", 0);
    run_op(8'h80, 8'h80, 1'b0, "t3", 0);
    run_op(8'h7F, 8'h7F, 1'b1, "t3b", 0);

    // Backpressure
    run_op(8'hC3, 8'h9E, 1'b1, "t4", 5);

    // Reset in the middle of RUN (cnt=3)
    in_a = 8'h37; in_b = 8'h5C; in_cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("t5.mid_valid", 32'(out_valid), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5.in_ready",  32'(in_ready),  32'd1);
    chk("t5.out_valid", 32'(out_valid), 32'd0);
    chk("t5.sum",       32'(out_sum),   32'd0);
    chk("t5.cout",      32'(out_cout),  32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("t5.ovf",       32'(out_ovf),   32'd0);
`endif
    run_op(8'h01, 8'h01, 1'b0, "t5b", 0);

    // Random single operations
    for (int i = 0; i < 6; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), "rnd", 0);
    end

    // Back-to-back streaming
    cyc = 0;
    nres = 0;
    out_ready = 1'b1;
    in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
    in_valid = 1'b1;
    while ((acc_t.size() < 3 || nres < 3) && cyc < 200) begin
      if (out_valid && qa.size() > 0) begin
        check_result("t6", qa[0], qb[0], qc[0]);
        void'(qa.pop_front()); void'(qb.pop_front()); void'(qc.pop_front());
        nres++;
      end
      acc = in_ready && in_valid;
      if (acc) begin
        acc_t.push_back(cyc);
        qa.push_back(in_a); qb.push_back(in_b); qc.push_back(in_cin);
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        if (acc_t.size() < 3) begin
          in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    chk("t6.results", 32'(nres), 32'd3);
    chk("t6.accepts", 32'(acc_t.size()), 32'd3);
    for (int i = 1; i < acc_t.size(); i++) begin
      chk("t6.spacing", 32'(acc_t[i] - acc_t[i-1]), 32'd10);
    end
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
